// File: rtl/clk_pkg.sv
// Clock-rate constants and divider helpers shared by the tick/blink logic.
package clk_pkg;

    localparam longint CLK_HZ = 100_000_000;

    // Rate is given in millihertz so fractional blink rates stay integral.
    // The half-period is rounded up, so 1.5 Hz yields 33_333_333.
    function automatic longint hz_to_div(input longint rate_mhz);
        return (CLK_HZ * 1000 + 2 * rate_mhz - 1) / (2 * rate_mhz) - 1;
    endfunction

    localparam longint DEFAULT_BLINK_DIV = hz_to_div(1500);

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, terminal-count register, registered tick and blink.
module tick_channel
    import clk_pkg::*;
#(
    parameter int          CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = 32'(DEFAULT_BLINK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
    output logic             tick,
    output logic             blink,
    output logic [CNT_W-1:0] div_q
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic             tick_reg, tick_next;
    logic             blink_reg, blink_next;

    // The wrap compare always sees div_reg, so a write lands one cycle later.
    always_comb begin
        cnt_next   = cnt_reg;
        div_next   = wr ? val : div_reg;
        tick_next  = 1'b0;
        blink_next = blink_reg;
        if (sync) begin
            cnt_next   = '0;
            blink_next = 1'b0;
        end else if (en) begin
            if (cnt_reg >= div_reg) begin
                cnt_next   = '0;
                tick_next  = 1'b1;
                blink_next = ~blink_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            div_reg   <= CNT_W'(DEFAULT_DIV);
            tick_reg  <= 1'b0;
            blink_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            div_reg   <= div_next;
            tick_reg  <= tick_next;
            blink_reg <= blink_next;
        end
    end

    assign tick  = tick_reg;
    assign blink = blink_reg;
    assign div_q = div_reg;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick/blink divider: channel write decode and terminal-count readback.
module tick_generator
    import clk_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = 32'(DEFAULT_BLINK_DIV),
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] blink,
    output logic [CNT_W-1:0]  div_rd
);

    logic [NUM_CH-1:0] ch_wr;
    logic [CNT_W-1:0]  div_q [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Channel numbers past NUM_CH-1 match no channel, so such writes drop.
            assign ch_wr[gi] = div_wr && (int'(div_ch) == gi);

            tick_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .sync  (sync),
                .wr    (ch_wr[gi]),
                .val   (div_val),
                .tick  (tick[gi]),
                .blink (blink[gi]),
                .div_q (div_q[gi])
            );
        end
    endgenerate

    always_comb begin
        div_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(div_ch) == i) div_rd = div_q[i];
        end
    end

endmodule

// File: tb/tb_tick_generator.sv
// Scoreboard bench for tick_generator: directed scenarios plus random traffic vs a reference model.
module tb_tick_generator;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
    localparam int DEFDIV = 3;

    logic              clk = 1'b0;
    logic              rst, en, sync, div_wr;
    logic [0:0]        div_ch;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] tick, blink;
    logic [CNT_W-1:0]  div_rd;

    tick_generator #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFDIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .tick    (tick),
        .blink   (blink),
        .div_rd  (div_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] tick;
        logic [1:0] blink;
        logic [3:0] rd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;

    // Reference state: elapsed cycles since last wrap, terminal count, blink level.
    int m_age[NUM_CH];
    int m_div[NUM_CH];
    int m_blink[NUM_CH];
    int m_tick[NUM_CH];

    task automatic step(input bit r, input bit e, input bit s,
                        input bit w, input int ch, input int v);
        exp_t x;
        int   old_div[NUM_CH];
        @(negedge clk);
        rst = r; en = e; sync = s; div_wr = w;
        div_ch = ch[0:0]; div_val = v[CNT_W-1:0];
        for (int i = 0; i < NUM_CH; i++) old_div[i] = m_div[i];
        for (int i = 0; i < NUM_CH; i++) begin
            if (r) begin
                m_age[i] = 0; m_div[i] = DEFDIV; m_blink[i] = 0; m_tick[i] = 0;
            end else begin
                if (w && ch == i) m_div[i] = v;
                m_tick[i] = 0;
                if (s) begin
                    m_age[i] = 0; m_blink[i] = 0;
                end else if (e) begin
                    if (m_age[i] >= old_div[i]) begin
                        m_age[i] = 0; m_tick[i] = 1; m_blink[i] = 1 - m_blink[i];
                    end else begin
                        m_age[i] = m_age[i] + 1;
                    end
                end
            end
        end
        cyc_no++;
        x.cyc = cyc_no;
        for (int i = 0; i < NUM_CH; i++) begin
            x.tick[i]  = m_tick[i][0];
            x.blink[i] = m_blink[i][0];
        end
        x.rd = (ch < NUM_CH) ? 4'(m_div[ch]) : 4'd0;
        q.push_back(x);
    endtask

    task automatic run(input int n, input bit e);
        for (int k = 0; k < n; k++) step(1'b0, e, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents tick/blink/div_rd; compare against queue head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (tick !== x.tick) begin
                    errors++;
                    $display("FAIL tick cyc=%0d got=%b want=%b", x.cyc, tick, x.tick);
                end
                checks++;
                if (blink !== x.blink) begin
                    errors++;
                    $display("FAIL blink cyc=%0d got=%b want=%b", x.cyc, blink, x.blink);
                end
                checks++;
                if (div_rd !== x.rd) begin
                    errors++;
                    $display("FAIL div_rd cyc=%0d got=%0d want=%0d", x.cyc, div_rd, x.rd);
                end
                $display("cyc=%0d tick=%b blink=%b div_rd=%0d", x.cyc, tick, blink, div_rd);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_age[i] = 0; m_div[i] = DEFDIV; m_blink[i] = 0; m_tick[i] = 0;
        end

        // Reset, then free-run with default divider
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        run(16, 1);

        // Channel 0 to div=0, channel 1 untouched
        step(0, 1, 0, 1, 0, 0);
        run(10, 1);

        // Channel 0 to div=12, wait for cnt=9, then lower to 5
        step(0, 1, 0, 1, 0, 12);
        for (int k = 0; k < 20 && m_age[0] != 9; k++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 5);
        run(14, 1);

        // Freeze at cnt=2 for 10 cycles, with a write allowed meanwhile
        for (int k = 0; k < 20 && m_age[1] != 2; k++) step(0, 1, 0, 0, 1, 0);
        run(4, 0);
        step(0, 0, 0, 1, 1, 3);
        run(5, 0);
        run(6, 1);

        // Skew channels, sync (with a write in the sync cycle), then equal divs
        step(0, 1, 0, 1, 0, 2);
        run(5, 1);
        step(0, 0, 1, 1, 0, 3);
        run(12, 1);

        // Reset mid-count with div=7 and sync in the same cycle
        step(0, 1, 0, 1, 0, 7);
        run(3, 1);
        step(1, 1, 1, 0, 0, 0);
        run(6, 1);

        // Random traffic with occasional sync/reset
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 9) < 2,
                 $urandom_range(0, NUM_CH - 1), $urandom_range(0, 15));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
